// File: rtl/mem_initiator.sv
// mem_initiator: requester-side controller for a single-port synchronous
// memory. It accepts read/write commands on a valid/ready request channel,
// drives registered memory-port signals, and returns the memory word on a
// valid/ready response channel. It also provides an init sweep that writes
// INIT_VALUE to every location.
// Optional build macro: MEM_INITIATOR_WRITE_VERIFY_EN adds a write-verify
// compare that drives rsp_error; without it rsp_error is tied low.
module mem_initiator #(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  input  logic                  init_start,
  output logic                  init_done,
  output logic                  busy,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP,
    INIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

  state_t                  state_q, state_d;
  logic                    req_ready_d;
  logic                    rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    init_done_d;
  logic                    mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_data_in_d;

`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
  // Latched command kind and write data, compared against the memory word.
  logic                    lat_write_q, lat_write_d;
  logic [DATA_WIDTH-1:0]   lat_wdata_q, lat_wdata_d;
  logic                    rsp_error_q, rsp_error_d;
  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  // Next-state and next-register values for every FSM phase.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    init_done_d   = 1'b0;
    mem_write_d   = mem_write;
    mem_address_d = mem_address;
    mem_data_in_d = mem_data_in;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
    lat_write_d   = lat_write_q;
    lat_wdata_d   = lat_wdata_q;
    rsp_error_d   = rsp_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (init_start) begin
          // Sweep wins over a same-cycle request; that request is not taken.
          state_d       = INIT;
          mem_address_d = '0;
          mem_data_in_d = INIT_VALUE;
          mem_write_d   = 1'b1;
        end else if (req_valid && req_ready) begin
          state_d       = ACCESS;
          mem_address_d = req_addr;
          mem_data_in_d = req_wdata;
          mem_write_d   = req_write;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
          lat_write_d   = req_write;
          lat_wdata_d   = req_wdata;
`endif
        end
      end
      ACCESS: begin
        // The memory performs the access on this edge.
        mem_write_d = 1'b0;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        rsp_rdata_d = mem_data_out;
        rsp_valid_d = 1'b1;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
        rsp_error_d = lat_write_q && (mem_data_out != lat_wdata_q);
`endif
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
          rsp_error_d = 1'b0;
`endif
          state_d     = IDLE;
        end
      end
      INIT: begin
        if (mem_address == ADDR_LAST) begin
          mem_write_d = 1'b0;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_address_d = mem_address + ADDR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any operation at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      init_done   <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      init_done   <= init_done_d;
      mem_write   <= mem_write_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
    end
  end

`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
  // Write-verify registers: latched command and the error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      lat_write_q <= lat_write_d;
      lat_wdata_q <= lat_wdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed self-checking bench for mem_initiator with a
// behavioural single-port memory (write-first registered data-out).
module tb_mem_initiator;

  logic       clock;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic       rsp_error;
  logic       init_start;
  logic       init_done;
  logic       busy;
  logic       mem_write;
  logic [2:0] mem_address;
  logic [3:0] mem_data_in;
  logic [3:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem_model [0:7];
  logic [3:0] mem_q;
  logic [3:0] corrupt;

  mem_initiator #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(4),
    .INIT_VALUE(4'h0)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .init_start   (init_start),
    .init_done    (init_done),
    .busy         (busy),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory: write-first, registered data-out.
  always @(posedge clock) begin
    if (mem_write) begin
      mem_model[mem_address] <= mem_data_in;
      mem_q                  <= mem_data_in;
    end else begin
      mem_q <= mem_model[mem_address];
    end
  end
  assign mem_data_out = mem_q ^ corrupt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then park on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Full command with handshake; rsp_ready is assumed high.
  task automatic do_op(input logic wr, input logic [2:0] addr, input logic [3:0] wd,
                       output logic [3:0] rd, output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_timeout", 32'(n < 20), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rsp_valid_timeout", 32'(n < 20), 32'd1);
    rd  = rsp_rdata;
    err = rsp_error;
    tick();
  endtask

  logic [3:0] rd;
  logic       err;
  logic       exp_err;
  int         n;

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    init_start = 1'b0;
    corrupt    = 4'h0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    reset_n = 1'b1;
    check("rel_req_ready_pre_edge", 32'(req_ready), 32'd0);
    tick();
    check("rel_req_ready_post_edge", 32'(req_ready), 32'd1);

    // Write addr 5 data A, cycle by cycle.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd5;
    req_wdata = 4'hA;
    tick();
    req_valid = 1'b0;
    check("wr_e0_mem_write", 32'(mem_write), 32'd1);
    check("wr_e0_mem_address", 32'(mem_address), 32'd5);
    check("wr_e0_mem_data_in", 32'(mem_data_in), 32'hA);
    check("wr_e0_req_ready", 32'(req_ready), 32'd0);
    check("wr_e0_busy", 32'(busy), 32'd1);
    tick();
    check("wr_e1_mem_write", 32'(mem_write), 32'd0);
    check("wr_e1_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("wr_e2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_e2_rsp_rdata", 32'(rsp_rdata), 32'hA);
    check("wr_e2_rsp_error", 32'(rsp_error), 32'd0);
    tick();
    check("wr_e3_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wr_e3_busy", 32'(busy), 32'd0);
    check("wr_e3_req_ready", 32'(req_ready), 32'd1);

    // Read-back of addr 5 with response backpressure.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd5;
    req_wdata = 4'h6;
    tick();
    req_valid = 1'b0;
    check("rd_e0_mem_write", 32'(mem_write), 32'd0);
    tick();
    check("rd_e1_mem_write", 32'(mem_write), 32'd0);
    tick();
    check("rd_e2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_e2_rsp_rdata", 32'(rsp_rdata), 32'hA);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'hA);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_mem_write", 32'(mem_write), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);

    // Init sweep, started together with a competing request.
    do_op(1'b1, 3'd0, 4'hF, rd, err);
    check("pre_init_wr0", 32'(rd), 32'hF);
    do_op(1'b1, 3'd7, 4'hF, rd, err);
    check("pre_init_wr7", 32'(rd), 32'hF);
    init_start = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 3'd2;
    tick();
    init_start = 1'b0;
    req_valid  = 1'b0;
    check("init_req_ready", 32'(req_ready), 32'd0);
    check("init_busy", 32'(busy), 32'd1);
    check("init_mem_data_in", 32'(mem_data_in), 32'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      check("init_sweep_write", 32'(mem_write), 32'd1);
      check("init_sweep_addr", 32'(mem_address), 32'(i));
      n += int'(init_done);
      tick();
    end
    check("init_early_done_pulses", 32'(n), 32'd0);
    check("init_done_pulse", 32'(init_done), 32'd1);
    check("init_end_mem_write", 32'(mem_write), 32'd0);
    check("init_end_busy", 32'(busy), 32'd0);
    tick();
    check("init_done_clear", 32'(init_done), 32'd0);
    check("init_no_stray_rsp", 32'(rsp_valid), 32'd0);
    do_op(1'b0, 3'd0, 4'h0, rd, err);
    check("init_rd0", 32'(rd), 32'h0);
    do_op(1'b0, 3'd7, 4'h0, rd, err);
    check("init_rd7", 32'(rd), 32'h0);
    do_op(1'b0, 3'd5, 4'h0, rd, err);
    check("init_rd5", 32'(rd), 32'h0);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, 3'(i), 4'(i + 8), rd, err);
    end
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n = 0;
    while (mem_address != 3'd3 && n < 20) begin
      tick();
      n++;
    end
    check("midreset_reach_addr3", 32'(n < 20), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_mem_write", 32'(mem_write), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 3'(i), 4'h0, rd, err);
      check("midreset_rd", 32'(rd), (i < 3) ? 32'h0 : 32'(i + 8));
    end

    // Write-verify with a corrupted memory read-out (2 written, 3 seen).
`ifdef MEM_INITIATOR_WRITE_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    corrupt = 4'h1;
    do_op(1'b1, 3'd4, 4'h2, rd, err);
    check("verify_rdata", 32'(rd), 32'h3);
    check("verify_error", 32'(err), 32'(exp_err));
    check("verify_error_cleared", 32'(rsp_error), 32'd0);
    corrupt = 4'h0;
    do_op(1'b0, 3'd4, 4'h0, rd, err);
    check("verify_readback", 32'(rd), 32'h2);
    check("verify_read_no_error", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
